// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential signed/unsigned divider.
package div_pkg;

    localparam int DIV_DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FIX
    } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Sign correction for a magnitude quotient/remainder pair.
// The quotient is negated when operand signs differ (truncation toward zero);
// the remainder follows the dividend's sign.
module div_sign_fix
    import div_pkg::*;
#(
    parameter int DW = DIV_DW_DEFAULT
) (
    input  logic [DW-1:0] quo_i,
    input  logic [DW-1:0] rem_i,
    input  logic          dividend_neg_i,
    input  logic          divisor_neg_i,
    input  logic          signed_mode_i,
    output logic [DW-1:0] quo_o,
    output logic [DW-1:0] rem_o
);

    // Conditional two's-complement negation of quotient and remainder.
    always_comb begin
        quo_o = quo_i;
        rem_o = rem_i;
        if (signed_mode_i && (dividend_neg_i ^ divisor_neg_i)) begin
            quo_o = -quo_i;
        end
        if (signed_mode_i && dividend_neg_i) begin
            rem_o = -rem_i;
        end
    end

endmodule

// File: rtl/signed_div_seq.sv
// Multi-cycle restoring radix-2 divider with start/done handshake.
// Fixed latency of DW+1 edges after the start edge, including divide-by-zero.
module signed_div_seq
    import div_pkg::*;
#(
    parameter int DW = DIV_DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          signed_mode,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic [DW-1:0] residue,
    output logic          div_by_zero,
    output logic          overflow
);

    localparam int CW = $clog2(DW + 1);
    localparam logic [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [DW-1:0] dvs_q, dvs_d;
    logic [DW-1:0] raw_q, raw_d;
    logic          sm_q, sm_d;
    logic          sa_q, sa_d;
    logic          sb_q, sb_d;
    logic          dbz_pend_q, dbz_pend_d;
    logic          ovf_pend_q, ovf_pend_d;
    logic          done_q, done_d;
    logic [DW-1:0] result_q, result_d;
    logic [DW-1:0] residue_q, residue_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [DW:0]   shifted;
    logic [DW:0]   diff;
    logic [DW-1:0] quo_fix;
    logic [DW-1:0] rem_fix;

    div_sign_fix #(
        .DW(DW)
    ) u_sign_fix (
        .quo_i         (quo_q),
        .rem_i         (rem_q),
        .dividend_neg_i(sa_q),
        .divisor_neg_i (sb_q),
        .signed_mode_i (sm_q),
        .quo_o         (quo_fix),
        .rem_o         (rem_fix)
    );

    // State, datapath and output registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            raw_q      <= '0;
            sm_q       <= 1'b0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            dbz_pend_q <= 1'b0;
            ovf_pend_q <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            residue_q  <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            raw_q      <= raw_d;
            sm_q       <= sm_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            dbz_pend_q <= dbz_pend_d;
            ovf_pend_q <= ovf_pend_d;
            done_q     <= done_d;
            result_q   <= result_d;
            residue_q  <= residue_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state logic: operand capture, shift-subtract iteration, result fix-up.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        raw_d      = raw_q;
        sm_d       = sm_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        dbz_pend_d = dbz_pend_q;
        ovf_pend_d = ovf_pend_q;
        done_d     = 1'b0;
        result_d   = result_q;
        residue_d  = residue_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;

        // Remainder can reach 2*|divisor|-1 after the shift, so trial needs DW+1 bits.
        shifted    = {rem_q, quo_q[DW-1]};
        diff       = shifted - {1'b0, dvs_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = DIVIDE;
                    sm_d       = signed_mode;
                    sa_d       = signed_mode & dividend[DW-1];
                    sb_d       = signed_mode & divisor[DW-1];
                    quo_d      = (signed_mode && dividend[DW-1]) ? -dividend : dividend;
                    dvs_d      = (signed_mode && divisor[DW-1])  ? -divisor  : divisor;
                    raw_d      = dividend;
                    rem_d      = '0;
                    cnt_d      = '0;
                    dbz_pend_d = (divisor == '0);
                    ovf_pend_d = signed_mode && (dividend == MIN_VAL) && (divisor == '1);
                end
            end
            DIVIDE: begin
                if (!diff[DW]) begin
                    rem_d = diff[DW-1:0];
                    quo_d = {quo_q[DW-2:0], 1'b1};
                end else begin
                    rem_d = shifted[DW-1:0];
                    quo_d = {quo_q[DW-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d   = IDLE;
                done_d    = 1'b1;
                result_d  = dbz_pend_q ? '1    : quo_fix;
                residue_d = dbz_pend_q ? raw_q : rem_fix;
                dbz_d     = dbz_pend_q;
                ovf_d     = ovf_pend_q & ~dbz_pend_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign result      = result_q;
    assign residue     = residue_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_signed_div_seq.sv
// Self-checking bench for signed_div_seq (DW=16) with an expected-result queue.
module tb_signed_div_seq;

    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0] res;
        logic [DW-1:0] rem;
        logic          dbz;
        logic          ovf;
        string         name;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic          signed_mode;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic [DW-1:0] residue;
    logic          div_by_zero;
    logic          overflow;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    signed_div_seq #(
        .DW(DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_mode(signed_mode),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .residue    (residue),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference using native integer division.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic sm, input string nm);
        exp_t e;
        int   ia;
        int   ib;
        int   q;
        int   r;
        e.name = nm;
        e.dbz  = 1'b0;
        e.ovf  = 1'b0;
        if (b == '0) begin
            e.res = '1;
            e.rem = a;
            e.dbz = 1'b1;
        end else begin
            if (sm) begin
                ia = int'($signed(a));
                ib = int'($signed(b));
                e.ovf = (a == 16'h8000) && (b == 16'hFFFF);
            end else begin
                ia = int'({16'h0000, a});
                ib = int'({16'h0000, b});
            end
            q = ia / ib;
            r = ia % ib;
            e.res = q[DW-1:0];
            e.rem = r[DW-1:0];
        end
        return e;
    endfunction

    // Drive one start pulse at the current time, push its expectation, and
    // scramble the operand inputs right after the accepting edge.
    task automatic launch(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic sm, input exp_t e);
        start       = 1'b1;
        dividend    = a;
        divisor     = b;
        signed_mode = sm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start       = 1'b0;
        dividend    = DW'($urandom);
        divisor     = DW'($urandom);
        signed_mode = 1'($urandom);
    endtask

    // Wait (bounded) for done; lat = base + edges waited, or -1 on timeout.
    task automatic wait_done(input int base, output int lat);
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                lat = base + e;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        start = 1'b0;
        signed_mode = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (result !== '0) begin n_err++; $display("FAIL reset_result: got %h want 0000", result); end
        n_cmp++; if (residue !== '0) begin n_err++; $display("FAIL reset_residue: got %h want 0000", residue); end
        n_cmp++; if ({div_by_zero, overflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {div_by_zero, overflow}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_plan;
        logic [DW-1:0] ta[8] = '{16'h0007, 16'hFFF9, 16'h0007, 16'h8000, 16'h1234, 16'hFFFF, 16'h1234, 16'h8000};
        logic [DW-1:0] tb[8] = '{16'h0002, 16'h0002, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0002, 16'h0000, 16'hFFFF};
        logic          ts[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [DW-1:0] tr[8] = '{16'h0003, 16'hFFFD, 16'hFFFD, 16'h8000, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h0000};
        logic [DW-1:0] tm[8] = '{16'h0001, 16'hFFFF, 16'h0001, 16'h0000, 16'h1234, 16'h0001, 16'h1234, 16'h8000};
        logic          tz[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic          tv[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_t e;
        exp_t got;
        int   lat;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            e.res = tr[i]; e.rem = tm[i]; e.dbz = tz[i]; e.ovf = tv[i];
            e.name = $sformatf("plan%0d", i);
            launch(ta[i], tb[i], ts[i], e);
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s_busy: got %b want 1", e.name, busy); end
            wait_done(0, lat);
            got = sb.pop_front();
            n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL %s_latency: got %0d want 17", got.name, lat); end
            n_cmp++; if (result !== got.res) begin n_err++; $display("FAIL %s_result: got %h want %h", got.name, result, got.res); end
            n_cmp++; if (residue !== got.rem) begin n_err++; $display("FAIL %s_residue: got %h want %h", got.name, residue, got.rem); end
            n_cmp++; if (div_by_zero !== got.dbz) begin n_err++; $display("FAIL %s_dbz: got %b want %b", got.name, div_by_zero, got.dbz); end
            n_cmp++; if (overflow !== got.ovf) begin n_err++; $display("FAIL %s_ovf: got %b want %b", got.name, overflow, got.ovf); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_busy_done: got %b want 0", got.name, busy); end
            repeat (3) @(negedge clk);
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL %s_done_pulse: got %b want 0", got.name, done); end
            n_cmp++; if ({result, residue} !== {got.res, got.rem}) begin n_err++; $display("FAIL %s_hold: got %h want %h", got.name, {result, residue}, {got.res, got.rem}); end
        end
    endtask

    task automatic test_random;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          sm;
        exp_t          got;
        int            lat;
        for (int i = 0; i < 24; i++) begin
            a  = DW'($urandom);
            b  = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(0, 9)) : DW'($urandom);
            sm = 1'($urandom);
            if (i % 8 == 3) begin
                a = 16'h8000; b = 16'hFFFF; sm = 1'b1;
            end
            @(negedge clk);
            launch(a, b, sm, model(a, b, sm, $sformatf("rand%0d", i)));
            wait_done(0, lat);
            got = sb.pop_front();
            n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL %s_latency: got %0d want 17", got.name, lat); end
            n_cmp++; if ({result, residue} !== {got.res, got.rem}) begin n_err++; $display("FAIL %s_value: got %h/%h want %h/%h (a=%h b=%h sm=%b)", got.name, result, residue, got.res, got.rem, a, b, sm); end
            n_cmp++; if ({div_by_zero, overflow} !== {got.dbz, got.ovf}) begin n_err++; $display("FAIL %s_flags: got %b want %b", got.name, {div_by_zero, overflow}, {got.dbz, got.ovf}); end
        end
    endtask

    task automatic test_back_to_back;
        exp_t got;
        int   lat;
        @(negedge clk);
        launch(16'h0064, 16'h0007, 1'b0, model(16'h0064, 16'h0007, 1'b0, "b2b_first"));
        wait_done(0, lat);
        got = sb.pop_front();
        n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL %s_latency: got %0d want 17", got.name, lat); end
        n_cmp++; if ({result, residue} !== {got.res, got.rem}) begin n_err++; $display("FAIL %s_value: got %h/%h want %h/%h", got.name, result, residue, got.res, got.rem); end
        // Restart in the done cycle: must be accepted on the very next edge.
        launch(16'hFF9C, 16'h0007, 1'b1, model(16'hFF9C, 16'h0007, 1'b1, "b2b_second"));
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
        wait_done(0, lat);
        got = sb.pop_front();
        n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL %s_latency: got %0d want 17", got.name, lat); end
        n_cmp++; if ({result, residue} !== {got.res, got.rem}) begin n_err++; $display("FAIL %s_value: got %h/%h want %h/%h", got.name, result, residue, got.res, got.rem); end
    endtask

    task automatic test_ignore_start;
        exp_t got;
        int   lat;
        int   extra;
        @(negedge clk);
        launch(16'h0007, 16'h0002, 1'b1, model(16'h0007, 16'h0002, 1'b1, "ign"));
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 16'h0100; divisor = 16'h0003; signed_mode = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(5, lat);
        got = sb.pop_front();
        n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL %s_latency: got %0d want 17", got.name, lat); end
        n_cmp++; if ({result, residue} !== {got.res, got.rem}) begin n_err++; $display("FAIL %s_value: got %h/%h want %h/%h", got.name, result, residue, got.res, got.rem); end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL ign_no_second_op: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_abort;
        exp_t got;
        int   lat;
        int   seen;
        @(negedge clk);
        launch(16'h0123, 16'h0010, 1'b0, model(16'h0123, 16'h0010, 1'b0, "abort"));
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 16'h4444; divisor = 16'h0002;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_cmp++; if ({busy, done, div_by_zero, overflow} !== 4'b0000) begin n_err++; $display("FAIL abort_ctrl: got %b want 0000", {busy, done, div_by_zero, overflow}); end
        n_cmp++; if ({result, residue} !== '0) begin n_err++; $display("FAIL abort_data: got %h want 0", {result, residue}); end
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen); end
        n_cmp++; if ({result, residue} !== '0) begin n_err++; $display("FAIL abort_outputs_after: got %h want 0", {result, residue}); end
        // Fresh operation after reset.
        @(negedge clk);
        launch(16'hFFF9, 16'hFFFE, 1'b1, model(16'hFFF9, 16'hFFFE, 1'b1, "post_reset"));
        wait_done(0, lat);
        got = sb.pop_front();
        n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL %s_latency: got %0d want 17", got.name, lat); end
        n_cmp++; if ({result, residue} !== {16'h0003, 16'hFFFF}) begin n_err++; $display("FAIL %s_value: got %h/%h want 0003/ffff", got.name, result, residue); end
        n_cmp++; if ({result, residue} !== {got.res, got.rem}) begin n_err++; $display("FAIL %s_model: got %h/%h want %h/%h", got.name, result, residue, got.res, got.rem); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_plan();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/signed_div_seq.md
Name: signed_div_seq

Overview:
- Parametrised multi-cycle signed/unsigned integer divider, the sequential successor to the combinational sign-correction stage.
- Takes raw operands and computes magnitudes internally, then runs a restoring radix-2 shift-subtract iteration.
- Applies quotient and remainder sign correction, and flags divide-by-zero and signed overflow.
- Sits behind the ALU/datapath control FSM and uses a start/done handshake.

Parameters:
- DW, 16, operand/result width in bits (must be >= 2).
- CW, $clog2(DW+1), iteration-counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while idle.
- signed_mode  input  1  1 = two's-complement operands; 0 = unsigned operands.
- dividend  input  DW  dividend; sampled with start.
- divisor  input  DW  divisor; sampled with start.
- busy  output  1  high from the edge after start is accepted until done.
- done  output  1  single-cycle pulse when result and residue are valid.
- result  output  DW  quotient.
- residue  output  DW  remainder.
- div_by_zero  output  1  divisor was 0; valid with done, held until next done.
- overflow  output  1  signed MIN / -1; valid with done, held until next done.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, div_by_zero and overflow = 0; result and residue = 0; counter = 0.
- States:
  - IDLE -> DIVIDE when start=1. Latch signed_mode, both operand signs (0 when signed_mode=0), |dividend| and |divisor| as DW-bit unsigned, and dbz = (divisor==0). Clear the partial remainder and counter.
  - DIVIDE: each edge, shift {rem, quo} left by 1, trial-subtract |divisor|, and set the quotient LSB if there is no borrow. Counter increments. After DW iterations -> FIX.
  - FIX: apply sign correction, register result, residue and flags, pulse done=1 for one cycle, busy=0. -> IDLE.
- Latency: start sampled at edge 0; done, result and flags are visible after edge DW+1. The latency is fixed regardless of operand values, including divide-by-zero.
- Sign rules (signed_mode=1):
  - Quotient is negated iff the dividend and divisor signs differ, i.e. truncation toward zero.
  - Remainder takes the dividend's sign.
  - Invariant: dividend = result*divisor + residue, with |residue| < |divisor|.
- Magnitude of -2^(DW-1) is 2^(DW-1), which fits in DW unsigned bits. No extra bit is needed.
- Overflow: signed_mode=1, dividend = 2^(DW-1) pattern, divisor = all-ones.
  - overflow=1.
  - result = 2^(DW-1) pattern (wraps).
  - residue = 0.
- Divide-by-zero:
  - div_by_zero=1, overflow=0.
  - result = all-ones.
  - residue = dividend as sampled (raw bits).
  - The iteration still runs; its output is discarded.
- Handshake:
  - start while busy or in FIX is ignored and has no side effects.
  - start may be reasserted in the cycle done is high; it is accepted on the next edge, since the state is IDLE then.
  - Operands may change after the start edge without effect.
- Output hold: result, residue and the flags hold their last values until the next FIX. done is 0 except for the one FIX cycle.
- Reset mid-operation: abort immediately to the reset values. No done pulse is produced for the aborted operation.
- Unsigned mode: no sign correction, and overflow is always 0.

Decomposition:
- Shared package div_pkg:
  - typedef enum logic [1:0] {IDLE, DIVIDE, FIX} div_state_e.
  - Localparam DIV_DW_DEFAULT = 16.
- Sub-module div_sign_fix, combinational, parameter DW. Inputs: raw quotient, raw remainder, dividend sign, divisor sign, signed_mode. Outputs: corrected quotient and remainder. It generalises the existing sign stage with remainder-sign handling.
- The top level holds the FSM, counter, shift registers and flag logic.

Test Plan (DW=16):
- Signed 7 / 2 -> done after edge 17; result 0x0003, residue 0x0001; both flags 0.
- Signed -7 / 2 and 7 / -2:
  - -7 / 2 -> result 0xFFFD, residue 0xFFFF.
  - 7 / -2 -> result 0xFFFD, residue 0x0001.
- Signed 0x8000 / 0xFFFF -> overflow=1, result 0x8000, residue 0x0000.
- Divisor 0, dividend 0x1234 -> div_by_zero=1, result 0xFFFF, residue 0x1234, done still at edge 17.
- Unsigned 0xFFFF / 0x0002 -> result 0x7FFF, residue 0x0001, overflow 0.
- Two further sequences:
  - Start at edge 0, a second start at edge 5 (ignored), then rst pulsed low at edge 8 -> no done pulse; all outputs 0.
  - A new start after reset completes normally.
